// File: rtl/timer_bus_master.sv
// Timer peripheral register-bus initiator: turns single host read/write
// commands into a select/ack bus cycle with an optional acknowledge timeout.
module timer_bus_master #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_wr,
  input  logic [3:0]  i_cmd_addr,
  input  logic [15:0] i_cmd_data,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_bus_select,
  output logic        o_bus_wr,
  output logic [3:0]  o_reg_addr,
  output logic [15:0] o_bus_data,
  input  logic [15:0] i_bus_data,
  input  logic        i_bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter value seen on the last allowed REQ edge (only meaningful when enabled).
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic             TO_EN   = (TIMEOUT_CYC != 0);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              req_first, req_first_n;

  logic              ready_n;
  logic              rsp_valid_n;
  logic [15:0]       rsp_data_n;
  logic              rsp_err_n;
  logic              sel_n;
  logic              wr_n;
  logic [3:0]        addr_n;
  logic [15:0]       bdata_n;

  logic              ack_seen;
  logic              timed_out;

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_first    <= 1'b0;
      o_cmd_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_data   <= '0;
      o_rsp_err    <= 1'b0;
      o_bus_select <= 1'b0;
      o_bus_wr     <= 1'b0;
      o_reg_addr   <= '0;
      o_bus_data   <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      req_first    <= req_first_n;
      o_cmd_ready  <= ready_n;
      o_rsp_valid  <= rsp_valid_n;
      o_rsp_data   <= rsp_data_n;
      o_rsp_err    <= rsp_err_n;
      o_bus_select <= sel_n;
      o_bus_wr     <= wr_n;
      o_reg_addr   <= addr_n;
      o_bus_data   <= bdata_n;
    end
  end

  // Next-state and next-output logic; bus outputs are registered, so the
  // values computed here appear on the bus one cycle after the deciding edge.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    req_first_n = req_first;
    ready_n     = o_cmd_ready;
    rsp_valid_n = 1'b0;
    rsp_data_n  = o_rsp_data;
    rsp_err_n   = o_rsp_err;
    sel_n       = o_bus_select;
    wr_n        = o_bus_wr;
    addr_n      = o_reg_addr;
    bdata_n     = o_bus_data;
    ack_seen    = 1'b0;
    timed_out   = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (i_cmd_valid) begin
          state_n     = REQ;
          req_first_n = 1'b1;
          ready_n     = 1'b0;
          sel_n       = 1'b1;
          wr_n        = i_cmd_wr;
          addr_n      = i_cmd_addr;
          bdata_n     = i_cmd_wr ? i_cmd_data : '0;
        end
      end

      REQ: begin
        cnt_n       = cnt + CNT_W'(1);
        req_first_n = 1'b0;
        // A stale ack from the peripheral is ignored on the first REQ cycle.
        ack_seen    = i_bus_ack && !req_first;
        timed_out   = TO_EN && (cnt == TO_LAST);
        if (ack_seen || timed_out) begin
          state_n     = GAP;
          sel_n       = 1'b0;
          wr_n        = 1'b0;
          addr_n      = '0;
          bdata_n     = '0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = !ack_seen;
          rsp_data_n  = (ack_seen && !o_bus_wr) ? i_bus_data : '0;
        end
      end

      GAP: begin
        if (!i_bus_ack) begin
          state_n = IDLE;
          cnt_n   = '0;
          ready_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
        sel_n   = 1'b0;
        wr_n    = 1'b0;
        addr_n  = '0;
        bdata_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_bus_master.sv
// Randomised bench for timer_bus_master: two instances (timeout 16 and 4)
// checked against a transaction-level model of ack/timeout timing.
module tb_timer_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_wr    [2];
  logic [3:0]  cmd_addr  [2];
  logic [15:0] cmd_data  [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        bus_sel   [2];
  logic        bus_wr    [2];
  logic [3:0]  bus_addr  [2];
  logic [15:0] bus_wdata [2];
  logic [15:0] bus_rdata [2];
  logic        bus_ack   [2];

  int          to_cyc    [2] = '{16, 4};
  logic [15:0] last_data [2];
  logic        last_err  [2];

  int n_tests = 0;
  int n_fail  = 0;

  timer_bus_master #(.TIMEOUT_CYC(16), .CNT_W(8)) dut0 (
    .i_sysclk(clk), .i_sysrst(rst),
    .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(cmd_ready[0]),
    .i_cmd_wr(cmd_wr[0]), .i_cmd_addr(cmd_addr[0]), .i_cmd_data(cmd_data[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0]),
    .o_bus_select(bus_sel[0]), .o_bus_wr(bus_wr[0]), .o_reg_addr(bus_addr[0]),
    .o_bus_data(bus_wdata[0]), .i_bus_data(bus_rdata[0]), .i_bus_ack(bus_ack[0])
  );

  timer_bus_master #(.TIMEOUT_CYC(4), .CNT_W(3)) dut1 (
    .i_sysclk(clk), .i_sysrst(rst),
    .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(cmd_ready[1]),
    .i_cmd_wr(cmd_wr[1]), .i_cmd_addr(cmd_addr[1]), .i_cmd_data(cmd_data[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1]),
    .o_bus_select(bus_sel[1]), .o_bus_wr(bus_wr[1]), .o_reg_addr(bus_addr[1]),
    .o_bus_data(bus_wdata[1]), .i_bus_data(bus_rdata[1]), .i_bus_ack(bus_ack[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_bus_idle(input int k, input string tag);
    check({tag, "_sel"},  32'(bus_sel[k]),   32'd0);
    check({tag, "_wr"},   32'(bus_wr[k]),    32'd0);
    check({tag, "_addr"}, 32'(bus_addr[k]),  32'd0);
    check({tag, "_data"}, 32'(bus_wdata[k]), 32'd0);
  endtask

  // One complete transaction on instance k. ack_delay = REQ cycle (1-based) in
  // which the peripheral raises ack and keeps it; 0 = never. hold = extra
  // cycles ack stays high after the acknowledged edge.
  task automatic do_txn(input int k, input logic wr, input logic [3:0] addr,
                        input logic [15:0] wdata, input int ack_delay,
                        input logic [15:0] rdata, input int hold);
    int          eff;
    int          endc;
    int          hold_eff;
    logic        err;
    logic [15:0] exp_data;
    int          guard;

    // Reference: ack only counts from the 2nd REQ cycle; timeout after to_cyc cycles.
    eff = (ack_delay == 0) ? 0 : ((ack_delay < 2) ? 2 : ack_delay);
    if (eff != 0 && (to_cyc[k] == 0 || eff <= to_cyc[k])) begin
      endc = eff;
      err  = 1'b0;
    end else begin
      endc = to_cyc[k];
      err  = 1'b1;
    end
    exp_data = (err || wr) ? 16'h0 : rdata;
    hold_eff = err ? 0 : hold;

    @(negedge clk);
    cmd_valid[k] = 1'b1;
    cmd_wr[k]    = wr;
    cmd_addr[k]  = addr;
    cmd_data[k]  = wdata;
    guard = 0;
    while (!cmd_ready[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 32'(cmd_ready[k]), 32'd1);
    @(negedge clk);
    cmd_valid[k] = 1'b0;

    for (int c = 1; c <= endc; c++) begin
      check("req_sel",   32'(bus_sel[k]),   32'd1);
      check("req_wr",    32'(bus_wr[k]),    32'(wr));
      check("req_addr",  32'(bus_addr[k]),  32'(addr));
      check("req_data",  32'(bus_wdata[k]), wr ? 32'(wdata) : 32'd0);
      check("req_ready", 32'(cmd_ready[k]), 32'd0);
      check("req_rspv",  32'(rsp_valid[k]), 32'd0);
      cmd_valid[k] = 1'($urandom);
      cmd_wr[k]    = 1'($urandom);
      cmd_addr[k]  = 4'($urandom);
      cmd_data[k]  = 16'($urandom);
      bus_ack[k]   = (ack_delay != 0 && c >= ack_delay);
      bus_rdata[k] = (c == endc && !err) ? rdata : 16'($urandom);
      @(negedge clk);
    end
    cmd_valid[k] = 1'b0;
    bus_rdata[k] = 16'($urandom);

    check_bus_idle(k, "rsp");
    check("rsp_valid", 32'(rsp_valid[k]), 32'd1);
    check("rsp_err",   32'(rsp_err[k]),   32'(err));
    check("rsp_data",  32'(rsp_data[k]),  32'(exp_data));
    check("rsp_ready", 32'(cmd_ready[k]), 32'd0);
    last_data[k] = exp_data;
    last_err[k]  = err;

    for (int h = 0; h < hold_eff; h++) begin
      bus_ack[k] = 1'b1;
      @(negedge clk);
      check("gap_sel",   32'(bus_sel[k]),   32'd0);
      check("gap_ready", 32'(cmd_ready[k]), 32'd0);
      check("gap_rspv",  32'(rsp_valid[k]), 32'd0);
    end
    bus_ack[k] = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready[k]), 32'd1);
    check("idle_rspv",  32'(rsp_valid[k]), 32'd0);
    check("idle_sel",   32'(bus_sel[k]),   32'd0);
    check("hold_data",  32'(rsp_data[k]),  32'(last_data[k]));
    check("hold_err",   32'(rsp_err[k]),   32'(last_err[k]));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_wr[k]    = 1'b0;
      cmd_addr[k]  = '0;
      cmd_data[k]  = '0;
      bus_rdata[k] = '0;
      bus_ack[k]   = 1'b0;
      last_data[k] = '0;
      last_err[k]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_bus_idle(k, "reset");
      check("reset_ready", 32'(cmd_ready[k]), 32'd1);
      check("reset_rspv",  32'(rsp_valid[k]), 32'd0);
      check("reset_rspd",  32'(rsp_data[k]),  32'd0);
      check("reset_err",   32'(rsp_err[k]),   32'd0);
    end

    // Directed cases
    do_txn(0, 1'b1, 4'd1, 16'h07DF, 2, 16'h0000, 0);  // write TCCR
    do_txn(0, 1'b0, 4'd2, 16'hFFFF, 2, 16'h3801, 0);  // read TCCR2
    do_txn(0, 1'b0, 4'd3, 16'h0000, 0, 16'h0000, 0);  // timeout after 16
    do_txn(0, 1'b0, 4'd5, 16'h0000, 3, 16'hA5C3, 5);  // ack held 5 cycles
    do_txn(0, 1'b1, 4'd4, 16'h02FF, 1, 16'h1234, 0);  // OCR write, early ack
    do_txn(1, 1'b0, 4'd3, 16'h0000, 4, 16'hBEEF, 0);  // ack on timeout edge
    do_txn(1, 1'b0, 4'd3, 16'h0000, 5, 16'hBEEF, 0);  // ack one cycle late

    // Reset during REQ of a TCST write
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_wr[0]    = 1'b1;
    cmd_addr[0]  = 4'd6;
    cmd_data[0]  = 16'h0010;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    check("rst_pre_sel", 32'(bus_sel[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_bus_idle(0, "midrst");
    check("midrst_rspv", 32'(rsp_valid[0]), 32'd0);
    rst = 1'b0;
    last_data[0] = '0;
    last_err[0]  = 1'b0;
    last_data[1] = '0;
    last_err[1]  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("postrst_rspv",  32'(rsp_valid[0]), 32'd0);
      check("postrst_ready", 32'(cmd_ready[0]), 32'd1);
    end
    do_txn(0, 1'b1, 4'd6, 16'h0010, 2, 16'h0000, 0);

    // Randomised transactions on both instances
    for (int i = 0; i < 40; i++) begin
      int k;
      k = (i % 3 == 2) ? 1 : 0;
      do_txn(k, 1'($urandom), 4'($urandom), 16'($urandom),
             int'($urandom_range(0, (k == 0) ? 20 : 6)), 16'($urandom),
             int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
